// File: rtl/trdb_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : trdb_packet_arbiter
// Description : Round-robin, packet-granular arbiter sharing one registered
//               packet word output among NREQ trace packet producers.
//               Optional packet counter enabled by TRDB_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module trdb_packet_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ*XLEN-1:0] req_word_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ-1:0]      req_last_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ-1:0]      cfg_enable_i,
    input  logic                 cfg_flush_i,
    input  logic                 stall_i,
    output logic [XLEN-1:0]      packet_word_o,
    output logic                 packet_word_valid_o,
    output logic                 packet_last_o,
    output logic [NREQ-1:0]      grant_o,
    output logic                 busy_o,
    output logic [CNTW-1:0]      pkt_count_o
);

    localparam int              c_IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NREQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [c_IDX_W-1:0]   r_owner_q, w_owner_d;
    logic [c_IDX_W-1:0]   r_rr_q, w_rr_d;
    logic [XLEN-1:0]      r_word_q, w_word_d;
    logic                 r_valid_q, w_valid_d;
    logic                 r_last_q, w_last_d;
    logic [NREQ-1:0]      r_grant_q, w_grant_d;

    logic [NREQ-1:0]      w_eligible;
    logic [NREQ-1:0]      w_ready;
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_pick;
    logic [c_IDX_W-1:0]   w_scan;
    logic [XLEN-1:0]      w_own_word;
    logic                 w_own_valid;
    logic                 w_own_last;
    logic                 w_accept;

    assign w_eligible  = req_valid_i & cfg_enable_i;
    assign w_own_valid = req_valid_i[r_owner_q];
    assign w_own_last  = req_last_i[r_owner_q];

    // First eligible requester at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_q;
        w_scan  = r_rr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_eligible[w_scan]) begin
                w_found = 1'b1;
                w_pick  = w_scan;
            end
            w_scan = (w_scan == c_LAST) ? '0 : w_scan + 1'b1;
        end
    end

    always_comb begin
        w_own_word = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (r_owner_q == c_IDX_W'(r)) begin
                w_own_word = req_word_i[r*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_owner_d = r_owner_q;
        w_rr_d    = r_rr_q;
        w_word_d  = r_word_q;
        w_last_d  = r_last_q;
        // Output word is consumed unless the sink stalls it.
        w_valid_d = r_valid_q & stall_i;
        w_ready   = '0;
        w_accept  = 1'b0;

        if (r_state_q == ST_IDLE) begin
            if (w_found) begin
                w_state_d = ST_LOCK;
                w_owner_d = w_pick;
            end
        end else begin
            w_accept           = w_own_valid & (~r_valid_q | ~stall_i);
            w_ready[r_owner_q] = w_accept;
            if (w_accept) begin
                w_word_d  = w_own_word;
                w_valid_d = 1'b1;
                w_last_d  = w_own_last;
                if (w_own_last) begin
                    w_state_d = ST_IDLE;
                    w_rr_d    = (r_owner_q == c_LAST) ? '0 : r_owner_q + 1'b1;
                end
            end
        end

        if (cfg_flush_i) begin
            w_state_d = ST_IDLE;
            w_rr_d    = '0;
            w_word_d  = '0;
            w_valid_d = 1'b0;
            w_last_d  = 1'b0;
            w_ready   = '0;
        end

        w_grant_d = '0;
        if (w_state_d == ST_LOCK) begin
            w_grant_d[w_owner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= ST_IDLE;
            r_owner_q <= '0;
            r_rr_q    <= '0;
            r_word_q  <= '0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_grant_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_owner_q <= w_owner_d;
            r_rr_q    <= w_rr_d;
            r_word_q  <= w_word_d;
            r_valid_q <= w_valid_d;
            r_last_q  <= w_last_d;
            r_grant_q <= w_grant_d;
        end
    end

`ifdef TRDB_ARB_STATS_EN
    logic [CNTW-1:0] r_cnt_q, w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (cfg_flush_i) begin
            w_cnt_d = '0;
        end else if (r_valid_q && r_last_q && !stall_i && (r_cnt_q != '1)) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign pkt_count_o = r_cnt_q;
`else
    assign pkt_count_o = '0;
`endif

    assign req_ready_o         = w_ready;
    assign packet_word_o       = r_word_q;
    assign packet_word_valid_o = r_valid_q;
    assign packet_last_o       = r_last_q;
    assign grant_o             = r_grant_q;
    assign busy_o              = (r_state_q == ST_LOCK) | r_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_trdb_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_trdb_packet_arbiter
// Description : Randomized scoreboard bench for trdb_packet_arbiter with a
//               packet-level round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trdb_packet_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int CNTW = 16;
`ifdef TRDB_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [XLEN-1:0] w;
        logic            l;
    } wd_t;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [NREQ*XLEN-1:0] req_word_i;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ-1:0]      req_last_i;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ-1:0]      cfg_enable_i;
    logic                 cfg_flush_i;
    logic                 stall_i;
    logic [XLEN-1:0]      packet_word_o;
    logic                 packet_word_valid_o;
    logic                 packet_last_o;
    logic [NREQ-1:0]      grant_o;
    logic                 busy_o;
    logic [CNTW-1:0]      pkt_count_o;

    trdb_packet_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .req_word_i          (req_word_i),
        .req_valid_i         (req_valid_i),
        .req_last_i          (req_last_i),
        .req_ready_o         (req_ready_o),
        .cfg_enable_i        (cfg_enable_i),
        .cfg_flush_i         (cfg_flush_i),
        .stall_i             (stall_i),
        .packet_word_o       (packet_word_o),
        .packet_word_valid_o (packet_word_valid_o),
        .packet_last_o       (packet_last_o),
        .grant_o             (grant_o),
        .busy_o              (busy_o),
        .pkt_count_o         (pkt_count_o)
    );

    always #5 clk = ~clk;

    wd_t         pend [NREQ][$];
    bit          mid  [NREQ];
    wd_t         exp_q[$];
    int          m_ptr = 0;
    int unsigned exp_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned stall_pct = 0;
    int unsigned gap_pct = 0;
    bit          flush_now = 0, flush_arm = 0, flushed_flag = 0;
    bit          mask_arm = 0, hold_arm = 0;
    logic [XLEN-1:0] flush_word = '0;
    int          hold_cnt = 0, rel_cnt = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_pkt(input int r, input int n, input logic [XLEN-1:0] base);
        for (int i = 0; i < n; i++) begin
            pend[r].push_back('{w: base + XLEN'(i), l: (i == n - 1)});
        end
    endtask

    // Reference: whole packets in round-robin order over requesters that
    // hold pending packets and are enabled; first decision may use its own mask.
    function automatic void model_schedule(input logic [NREQ-1:0] m_first, input logic [NREQ-1:0] m_rest);
        wd_t             mp [NREQ][$];
        wd_t             w;
        logic [NREQ-1:0] m;
        bit              first;
        int              pick, idx;
        first = 1'b1;
        for (int r = 0; r < NREQ; r++) mp[r] = pend[r];
        while (1) begin
            m    = first ? m_first : m_rest;
            pick = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (pick < 0 && m[idx] && mp[idx].size() > 0) pick = idx;
            end
            if (pick < 0) break;
            first = 1'b0;
            do begin
                w = mp[pick].pop_front();
                exp_q.push_back(w);
            end while (!w.l);
            m_ptr = (pick + 1) % NREQ;
        end
    endfunction

    task automatic step();
        @(negedge clk);
        cfg_flush_i = flush_now;
        if (flush_arm && packet_word_valid_o && packet_word_o == flush_word) begin
            cfg_flush_i  = 1'b1;
            flush_arm    = 1'b0;
            flushed_flag = 1'b1;
        end
        if (mask_arm && grant_o == 3'b001) begin
            cfg_enable_i = 3'b110;
            mask_arm     = 1'b0;
        end
        if (hold_cnt > 0) begin
            stall_i = 1'b1;
            hold_cnt--;
            if (hold_cnt == 0) rel_cnt = 2;
        end else if (rel_cnt > 0) begin
            stall_i = 1'b0;
            if (rel_cnt == 1)
                chk(packet_word_valid_o && packet_word_o == 32'h0BADF00D, "stall_release_next", packet_word_o, 32'h0BADF00D);
            rel_cnt--;
        end else if (hold_arm && packet_word_valid_o && packet_word_o == 32'hDEADBEEF) begin
            stall_i  = 1'b1;
            hold_arm = 1'b0;
            hold_cnt = 3;
        end else begin
            stall_i = ($urandom_range(99) < stall_pct);
        end
        for (int r = 0; r < NREQ; r++) begin
            if (pend[r].size() > 0 && !(mid[r] && ($urandom_range(99) < gap_pct))) begin
                req_valid_i[r]              = 1'b1;
                req_word_i[r*XLEN +: XLEN]  = pend[r][0].w;
                req_last_i[r]               = pend[r][0].l;
            end else begin
                req_valid_i[r]              = 1'b0;
                req_word_i[r*XLEN +: XLEN]  = '0;
                req_last_i[r]               = 1'b0;
            end
        end
        #1;
        chk(((req_ready_o & ~req_valid_i) == '0) && $onehot0(req_ready_o), "ready_legal", req_ready_o, req_valid_i);
        if (cfg_flush_i || (stall_i && packet_word_valid_o))
            chk(req_ready_o == '0, "ready_blocked", req_ready_o, 0);
        for (int r = 0; r < NREQ; r++) begin
            if (req_ready_o[r] && pend[r].size() > 0) begin
                mid[r] = !pend[r][0].l;
                void'(pend[r].pop_front());
            end
        end
    endtask

    task automatic after_flush();
        for (int r = 0; r < NREQ; r++) begin
            pend[r].delete();
            mid[r] = 1'b0;
        end
        m_ptr   = 0;
        exp_cnt = 0;
    endtask

    task automatic flush_checks();
        chk(!packet_word_valid_o, "flush_valid", packet_word_valid_o, 0);
        chk(grant_o == '0, "flush_grant", grant_o, 0);
        chk(pkt_count_o == '0, "flush_count", pkt_count_o, 0);
        chk(!busy_o, "flush_busy", busy_o, 0);
    endtask

    task automatic do_flush();
        flush_now = 1'b1;
        step();
        flush_now = 1'b0;
        after_flush();
        step();
        flush_checks();
        exp_q.delete();
    endtask

    task automatic drain(input string name);
        int t;
        logic [CNTW-1:0] ec;
        t = 0;
        while ((exp_q.size() > 0 || busy_o) && t < 3000) begin
            step();
            t++;
        end
        chk(t < 3000 && exp_q.size() == 0, name, exp_q.size(), 0);
        ec = STATS ? CNTW'(exp_cnt) : {CNTW{1'b0}};
        chk(pkt_count_o == ec, "pkt_count", pkt_count_o, ec);
    endtask

    // Scoreboard monitor: pops one expected word per delivered output word.
    initial begin : monitor
        wd_t             e;
        bit              p_hold;
        logic [XLEN-1:0] p_word;
        logic            p_last;
        p_hold = 1'b0;
        p_word = '0;
        p_last = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (rst_i) begin
                p_hold = 1'b0;
            end else begin
                if (p_hold)
                    chk(packet_word_valid_o && packet_word_o == p_word && packet_last_o == p_last,
                        "hold_stable", packet_word_o, p_word);
                if (packet_word_valid_o && !stall_i) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_word", packet_word_o, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(packet_word_o == e.w && packet_last_o == e.l, "out_word",
                            {31'b0, packet_last_o, packet_word_o}, {31'b0, e.l, e.w});
                        if (e.l && exp_cnt < (2**CNTW - 1)) exp_cnt++;
                    end
                end
                p_hold = packet_word_valid_o && stall_i && !cfg_flush_i;
                p_word = packet_word_o;
                p_last = packet_last_o;
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [NREQ-1:0] g_log [1:6];
        logic            v_log [1:6];
        logic            l_log [1:6];
        logic [XLEN-1:0] w_log [1:6];
        int              t, npk;

        req_word_i   = '0;
        req_valid_i  = '0;
        req_last_i   = '0;
        cfg_enable_i = 3'b111;
        cfg_flush_i  = 1'b0;
        stall_i      = 1'b0;
        rst_i        = 1'b1;

        step();
        step();
        chk(!packet_word_valid_o && packet_word_o == '0 && !packet_last_o, "reset_out", packet_word_o, 0);
        chk(grant_o == '0, "reset_grant", grant_o, 0);
        chk(!busy_o, "reset_busy", busy_o, 0);
        chk(pkt_count_o == '0, "reset_count", pkt_count_o, 0);
        rst_i = 1'b0;

        // Two 2-word packets, exact cycle timing.
        push_pkt(0, 2, 32'hA000_0000);
        push_pkt(2, 2, 32'hC000_0000);
        model_schedule('1, '1);
        for (int c = 1; c <= 6; c++) begin
            step();
            g_log[c] = grant_o;
            v_log[c] = packet_word_valid_o;
            l_log[c] = packet_last_o;
            w_log[c] = packet_word_o;
        end
        chk(g_log[2] == 3'b001 && !v_log[2], "t2_grant0", g_log[2], 3'b001);
        chk(v_log[3] && w_log[3] == 32'hA000_0000, "t2_word_c3", w_log[3], 32'hA000_0000);
        chk(v_log[4] && l_log[4] && w_log[4] == 32'hA000_0001, "t2_word_c4", w_log[4], 32'hA000_0001);
        chk(g_log[5] == 3'b100, "t2_grant2", g_log[5], 3'b100);
        chk(v_log[6] && w_log[6] == 32'hC000_0000, "t2_word_c6", w_log[6], 32'hC000_0000);
        drain("drain_basic");

        // Fairness: six single-word packets with random stall.
        do_flush();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < NREQ; r++)
                push_pkt(r, 1, 32'hF000_0000 + XLEN'(16 * k + r));
        model_schedule('1, '1);
        stall_pct = 30;
        drain("drain_fair");
        stall_pct = 0;

        // Held output under a 4-cycle stall.
        push_pkt(2, 0, '0);
        pend[2].push_back('{w: 32'hDEADBEEF, l: 1'b0});
        pend[2].push_back('{w: 32'h0BADF00D, l: 1'b1});
        hold_arm = 1'b1;
        model_schedule('1, '1);
        drain("drain_hold");
        chk(!hold_arm && hold_cnt == 0 && rel_cnt == 0, "hold_seen", hold_arm, 0);

        // Randomized rounds: variable-length packets, gaps and stalls.
        stall_pct = 25;
        gap_pct   = 25;
        for (int round = 0; round < 5; round++) begin
            for (int r = 0; r < NREQ; r++) begin
                npk = $urandom_range(3);
                for (int p = 0; p < npk; p++)
                    push_pkt(r, $urandom_range(4, 1), $urandom);
            end
            model_schedule('1, '1);
            drain("drain_random");
        end
        stall_pct = 0;
        gap_pct   = 0;

        // Mask requester 0 while it owns a 3-word packet.
        do_flush();
        push_pkt(0, 3, 32'h1000_0000);
        push_pkt(0, 1, 32'h1100_0000);
        push_pkt(0, 1, 32'h1200_0000);
        for (int k = 0; k < 3; k++) push_pkt(1, 1, 32'h2000_0000 + XLEN'(k));
        mask_arm  = 1'b1;
        stall_pct = 20;
        model_schedule(3'b111, 3'b110);
        drain("drain_mask");
        stall_pct = 0;
        chk(!mask_arm && cfg_enable_i == 3'b110, "mask_applied", cfg_enable_i, 3'b110);
        for (int k = 0; k < 10; k++) begin
            step();
            chk(grant_o == '0 && !packet_word_valid_o, "masked_idle", grant_o, 0);
        end
        do_flush();
        cfg_enable_i = 3'b111;

        // Flush during word 2 of a 4-word packet; arbitration restarts at 0.
        push_pkt(0, 1, 32'h4000_0000);
        model_schedule('1, '1);
        drain("drain_pre_flush");
        push_pkt(1, 4, 32'h5100_0000);
        model_schedule('1, '1);
        flush_word   = 32'h5100_0001;
        flush_arm    = 1'b1;
        flushed_flag = 1'b0;
        t = 0;
        while (!flushed_flag && t < 100) begin
            step();
            t++;
        end
        chk(flushed_flag, "flush_trigger", flushed_flag, 1);
        after_flush();
        step();
        flush_checks();
        exp_q.delete();
        push_pkt(1, 1, 32'h6100_0000);
        push_pkt(0, 1, 32'h6000_0000);
        model_schedule('1, '1);
        drain("drain_post_flush");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
